// File: rtl/vme_jtag_shift_engine.sv
// VME-to-JTAG shift engine: runs one header/shift/trailer scan on the selected chains
// and returns the TDO bits captured during the shift phase.
module vme_jtag_shift_engine #(
  parameter int NCHAIN  = 7,
  parameter int DW      = 16,
  parameter int TCK_DIV = 2
) (
  input  logic                  FPGACLK,
  input  logic                  IGLOBALRST,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic [$clog2(DW)-1:0] CMD_NBITS,
  input  logic [1:0]            CMD_HDR,
  input  logic [1:0]            CMD_TRL,
  input  logic [DW-1:0]         CMD_TDI,
  input  logic [NCHAIN-1:0]     CHAIN_SEL,
  output logic [NCHAIN-1:0]     TCK,
  output logic                  TMS,
  output logic                  TDI,
  input  logic [NCHAIN-1:0]     TDO,
  output logic [DW-1:0]         TDO_DATA,
  output logic                  TDO_VALID,
  output logic                  BUSY
);

  localparam int NW = $clog2(DW);
  localparam int SW = (NW > 3) ? NW : 3;
  localparam int PW = $clog2(2 * TCK_DIV);
  localparam logic [PW-1:0] P_RISE = PW'(TCK_DIV - 1);
  localparam logic [PW-1:0] P_HIGH = PW'(TCK_DIV);
  localparam logic [PW-1:0] P_LAST = PW'(2 * TCK_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_SHIFT, S_TRL, S_DONE} state_t;

  state_t              state_reg, state_next, state_after;
  logic [PW-1:0]       pcnt_reg, pcnt_next;
  logic [SW-1:0]       step_reg, step_next, step_last;
  logic [NW-1:0]       nbits_reg, nbits_next;
  logic [1:0]          hdr_reg, hdr_next;
  logic [1:0]          trl_reg, trl_next;
  logic [DW-1:0]       tdi_word_reg, tdi_word_next;
  logic [NCHAIN-1:0]   sel_reg, sel_next;
  logic [DW-1:0]       cap_reg, cap_next;
  logic [DW-1:0]       tdo_data_reg, tdo_data_next;
  logic                tdo_valid_reg, tdo_valid_next;
  logic [NCHAIN-1:0]   tck_reg, tck_next;
  logic                tms_reg, tms_next;
  logic                tdi_reg, tdi_next;
  logic                tdo_bit;

  // TDO comes from the lowest-index selected chain; no selection reads as 0.
  always_comb begin
    tdo_bit = 1'b0;
    for (int i = NCHAIN - 1; i >= 0; i--) begin
      if (sel_reg[i]) tdo_bit = TDO[i];
    end
  end

  always_comb begin
    step_last   = '0;
    state_after = S_DONE;
    case (state_reg)
      S_HDR: begin
        case (hdr_reg)
          2'b01:   step_last = SW'(3);
          2'b10:   step_last = SW'(2);
          default: step_last = SW'(5);
        endcase
        state_after = (hdr_reg == 2'b11) ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        step_last   = SW'(nbits_reg);
        state_after = (trl_reg != 2'b00) ? S_TRL : S_DONE;
      end
      S_TRL:   step_last = (trl_reg == 2'b10) ? SW'(0) : SW'(1);
      default: ;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    pcnt_next      = pcnt_reg;
    step_next      = step_reg;
    nbits_next     = nbits_reg;
    hdr_next       = hdr_reg;
    trl_next       = trl_reg;
    tdi_word_next  = tdi_word_reg;
    sel_next       = sel_reg;
    cap_next       = cap_reg;
    tdo_data_next  = tdo_data_reg;
    tdo_valid_next = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (CMD_VALID) begin
          nbits_next    = CMD_NBITS;
          hdr_next      = CMD_HDR;
          trl_next      = CMD_TRL;
          tdi_word_next = CMD_TDI;
          sel_next      = CHAIN_SEL;
          cap_next      = '0;
          pcnt_next     = '0;
          step_next     = '0;
          state_next    = (CMD_HDR != 2'b00) ? S_HDR : S_SHIFT;
        end
      end
      S_HDR, S_SHIFT, S_TRL: begin
        // Sample on the clock edge that raises TCK.
        if (state_reg == S_SHIFT && pcnt_reg == P_RISE) cap_next[step_reg[NW-1:0]] = tdo_bit;
        if (pcnt_reg == P_LAST) begin
          pcnt_next = '0;
          if (step_reg == step_last) begin
            step_next  = '0;
            state_next = state_after;
            if (state_after == S_DONE) begin
              tdo_valid_next = 1'b1;
              tdo_data_next  = cap_reg;
            end
          end else begin
            step_next = step_reg + SW'(1);
          end
        end else begin
          pcnt_next = pcnt_reg + PW'(1);
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Pin levels are registered from the next-state view; TMS/TDI only move at period start (TCK low).
  always_comb begin
    tck_next = '0;
    tms_next = tms_reg;
    tdi_next = tdi_reg;
    case (state_next)
      S_HDR: begin
        tdi_next = 1'b0;
        case (hdr_next)
          2'b01:   tms_next = (step_next < SW'(2));
          2'b10:   tms_next = (step_next == SW'(0));
          default: tms_next = (step_next < SW'(5));
        endcase
      end
      S_SHIFT: begin
        tdi_next = tdi_word_next[step_next[NW-1:0]];
        tms_next = (trl_next != 2'b00) && (step_next == SW'(nbits_next));
      end
      S_TRL: begin
        tdi_next = 1'b0;
        tms_next = (trl_next != 2'b10) && (step_next == SW'(0));
      end
      default: ;
    endcase
    if ((state_next == S_HDR || state_next == S_SHIFT || state_next == S_TRL) &&
        pcnt_next >= P_HIGH) begin
      tck_next = sel_next;
    end
  end

  always_ff @(posedge FPGACLK or posedge IGLOBALRST) begin
    if (IGLOBALRST) begin
      state_reg     <= S_IDLE;
      pcnt_reg      <= '0;
      step_reg      <= '0;
      nbits_reg     <= '0;
      hdr_reg       <= '0;
      trl_reg       <= '0;
      tdi_word_reg  <= '0;
      sel_reg       <= '0;
      cap_reg       <= '0;
      tdo_data_reg  <= '0;
      tdo_valid_reg <= 1'b0;
      tck_reg       <= '0;
      tms_reg       <= 1'b1;
      tdi_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pcnt_reg      <= pcnt_next;
      step_reg      <= step_next;
      nbits_reg     <= nbits_next;
      hdr_reg       <= hdr_next;
      trl_reg       <= trl_next;
      tdi_word_reg  <= tdi_word_next;
      sel_reg       <= sel_next;
      cap_reg       <= cap_next;
      tdo_data_reg  <= tdo_data_next;
      tdo_valid_reg <= tdo_valid_next;
      tck_reg       <= tck_next;
      tms_reg       <= tms_next;
      tdi_reg       <= tdi_next;
    end
  end

  assign CMD_READY = (state_reg == S_IDLE);
  assign BUSY      = ~CMD_READY;
  assign TCK       = tck_reg;
  assign TMS       = tms_reg;
  assign TDI       = tdi_reg;
  assign TDO_DATA  = tdo_data_reg;
  assign TDO_VALID = tdo_valid_reg;

endmodule
